// File: rtl/stroke_history_pkg.sv
// Shared types for stroke_history: FSM states, history entry layout, pointer helper.
// STROKE_GROUP_EN adds the stroke-start bit to each stored entry.
package stroke_history_pkg;

  localparam int unsigned SH_X_W    = 8;
  localparam int unsigned SH_Y_W    = 8;
  localparam int unsigned SH_C_W    = 3;
  localparam int unsigned SH_DEPTH  = 16;
  localparam int unsigned SH_ADDR_W = $clog2(SH_DEPTH);
  localparam int unsigned SH_PTR_W  = SH_ADDR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UNDO = 2'd1,
    ST_REDO = 2'd2
  } state_t;

  typedef struct packed {
`ifdef STROKE_GROUP_EN
    logic              start;
`endif
    logic [SH_X_W-1:0] x;
    logic [SH_Y_W-1:0] y;
    logic [SH_C_W-1:0] col_new;
    logic [SH_C_W-1:0] col_old;
  } entry_t;

  // Distance from b forward to a, wrapping modulo 2^SH_PTR_W.
  function automatic logic [SH_PTR_W-1:0] ptr_diff(input logic [SH_PTR_W-1:0] a,
                                                   input logic [SH_PTR_W-1:0] b);
    return SH_PTR_W'(a - b);
  endfunction

endpackage

// File: rtl/stroke_history_if.sv
// Save-side, replay-side and status signals of stroke_history.
interface stroke_history_if #(
  parameter int unsigned X_W = 8,
  parameter int unsigned Y_W = 8,
  parameter int unsigned C_W = 3
);
  logic           save;
  logic           save_start;
  logic [X_W-1:0] x_in;
  logic [Y_W-1:0] y_in;
  logic [C_W-1:0] col_new;
  logic [C_W-1:0] col_old;
  logic           undo;
  logic           redo;
  logic           out_valid;
  logic           out_ready;
  logic [X_W-1:0] x_out;
  logic [Y_W-1:0] y_out;
  logic [C_W-1:0] col_out;
  logic           out_is_redo;
  logic           busy;
  logic           done;
  logic           can_undo;
  logic           can_redo;
  logic           overflow;
  logic           save_drop;

  modport master (
    output save, save_start, x_in, y_in, col_new, col_old, undo, redo, out_ready,
    input  out_valid, x_out, y_out, col_out, out_is_redo, busy, done,
           can_undo, can_redo, overflow, save_drop
  );

  modport slave (
    input  save, save_start, x_in, y_in, col_new, col_old, undo, redo, out_ready,
    output out_valid, x_out, y_out, col_out, out_is_redo, busy, done,
           can_undo, can_redo, overflow, save_drop
  );

endinterface

// File: rtl/history_ram.sv
// History storage: register array with one write port and two combinational reads.
module history_ram
  import stroke_history_pkg::*;
#(
  parameter  int unsigned DEPTH  = SH_DEPTH,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  entry_t            wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output entry_t            rdata_a_c,
  input  logic [ADDR_W-1:0] raddr_b,
  output entry_t            rdata_b_c
);

  entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a_c = mem[raddr_a];
  assign rdata_b_c = mem[raddr_b];

endmodule

// File: rtl/stroke_history.sv
// Circular paint history with stroke-wise undo/redo replay over a valid/ready port.
// STROKE_GROUP_EN: when undefined every entry is its own stroke and save_start is ignored.
module stroke_history
  import stroke_history_pkg::*;
#(
  parameter int unsigned X_W   = SH_X_W,
  parameter int unsigned Y_W   = SH_Y_W,
  parameter int unsigned C_W   = SH_C_W,
  parameter int unsigned DEPTH = SH_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  stroke_history_if.slave   bus
);

  localparam int unsigned PTR_W  = $clog2(DEPTH) + 1;
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  state_t           state_q, state_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] cursor_q, cursor_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic             overflow_q, overflow_d;
  logic             done_q, done_d;
  logic             save_drop_q, save_drop_d;
  logic             can_undo_q, can_undo_d;
  logic             can_redo_q, can_redo_d;
  logic             busy_q, busy_d;
  logic             out_valid_q, out_valid_d;
  logic             out_is_redo_q, out_is_redo_d;
  logic [X_W-1:0]   x_out_q, x_out_d;
  logic [Y_W-1:0]   y_out_q, y_out_d;
  logic [C_W-1:0]   col_out_q, col_out_d;

  logic             we_c;
  entry_t           wdata_c;
  logic [ADDR_W-1:0] raddr_a_c, raddr_b_c;
  entry_t           rd_a_c, rd_b_c;
  logic             cur_start_c, nxt_start_c;
  logic [PTR_W-1:0] cursor_dec_c, cursor_inc_c;

  history_ram #(.DEPTH(DEPTH)) u_ram (
    .clk       (clk),
    .we        (we_c),
    .waddr     (cursor_q[ADDR_W-1:0]),
    .wdata     (wdata_c),
    .raddr_a   (raddr_a_c),
    .rdata_a_c (rd_a_c),
    .raddr_b   (raddr_b_c),
    .rdata_b_c (rd_b_c)
  );

  assign cursor_dec_c = cursor_q - PTR_W'(1);
  assign cursor_inc_c = cursor_q + PTR_W'(1);

  // Entry being written on a save.
  always_comb begin
    wdata_c         = '0;
`ifdef STROKE_GROUP_EN
    wdata_c.start   = bus.save_start;
`endif
    wdata_c.x       = bus.x_in;
    wdata_c.y       = bus.y_in;
    wdata_c.col_new = bus.col_new;
    wdata_c.col_old = bus.col_old;
  end

  // Port a: entry under the replay head; port b: the one replayed after it.
  always_comb begin
    raddr_a_c = cursor_q[ADDR_W-1:0];
    raddr_b_c = cursor_q[ADDR_W-1:0];
    case (state_q)
      ST_UNDO: begin
        raddr_a_c = ADDR_W'(cursor_dec_c);
        raddr_b_c = ADDR_W'(cursor_q - PTR_W'(2));
      end
      ST_REDO: begin
        raddr_a_c = cursor_q[ADDR_W-1:0];
        raddr_b_c = ADDR_W'(cursor_inc_c);
      end
      default: begin
        raddr_a_c = bus.undo ? ADDR_W'(cursor_dec_c) : cursor_q[ADDR_W-1:0];
        raddr_b_c = cursor_q[ADDR_W-1:0];
      end
    endcase
  end

`ifdef STROKE_GROUP_EN
  assign cur_start_c = rd_a_c.start;
  assign nxt_start_c = rd_b_c.start;
`else
  assign cur_start_c = 1'b1;
  assign nxt_start_c = 1'b1;
  logic unused_save_start;
  assign unused_save_start = bus.save_start;
`endif

  // Next-state, pointer and registered-output logic.
  always_comb begin
    state_d       = state_q;
    tail_d        = tail_q;
    cursor_d      = cursor_q;
    head_d        = head_q;
    overflow_d    = overflow_q;
    done_d        = 1'b0;
    save_drop_d   = bus.save && (state_q != ST_IDLE);
    out_valid_d   = out_valid_q;
    out_is_redo_d = out_is_redo_q;
    x_out_d       = x_out_q;
    y_out_d       = y_out_q;
    col_out_d     = col_out_q;
    we_c          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.save) begin
          we_c = 1'b1;
          if (ptr_diff(cursor_q, tail_q) == SH_PTR_W'(DEPTH)) begin
            tail_d     = tail_q + PTR_W'(1);
            overflow_d = 1'b1;
          end
          cursor_d = cursor_inc_c;
          head_d   = cursor_inc_c;
        end else if (bus.undo && (cursor_q != tail_q)) begin
          state_d       = ST_UNDO;
          out_valid_d   = 1'b1;
          out_is_redo_d = 1'b0;
          x_out_d       = rd_a_c.x;
          y_out_d       = rd_a_c.y;
          col_out_d     = rd_a_c.col_old;
        end else if (bus.redo && (head_q != cursor_q)) begin
          state_d       = ST_REDO;
          out_valid_d   = 1'b1;
          out_is_redo_d = 1'b1;
          x_out_d       = rd_a_c.x;
          y_out_d       = rd_a_c.y;
          col_out_d     = rd_a_c.col_new;
        end
      end

      ST_UNDO: begin
        if (out_valid_q && bus.out_ready) begin
          cursor_d = cursor_dec_c;
          if (cur_start_c || (cursor_dec_c == tail_q)) begin
            state_d       = ST_IDLE;
            done_d        = 1'b1;
            out_valid_d   = 1'b0;
            out_is_redo_d = 1'b0;
            x_out_d       = '0;
            y_out_d       = '0;
            col_out_d     = '0;
          end else begin
            x_out_d   = rd_b_c.x;
            y_out_d   = rd_b_c.y;
            col_out_d = rd_b_c.col_old;
          end
        end
      end

      ST_REDO: begin
        if (out_valid_q && bus.out_ready) begin
          cursor_d = cursor_inc_c;
          if ((cursor_inc_c == head_q) || nxt_start_c) begin
            state_d       = ST_IDLE;
            done_d        = 1'b1;
            out_valid_d   = 1'b0;
            out_is_redo_d = 1'b0;
            x_out_d       = '0;
            y_out_d       = '0;
            col_out_d     = '0;
          end else begin
            x_out_d   = rd_b_c.x;
            y_out_d   = rd_b_c.y;
            col_out_d = rd_b_c.col_new;
          end
        end
      end

      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    busy_d     = (state_d != ST_IDLE);
    can_undo_d = (state_d == ST_IDLE) && (cursor_d != tail_d);
    can_redo_d = (state_d == ST_IDLE) && (head_d != cursor_d);
  end

  // Synchronous reset abandons any replay without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      tail_q        <= '0;
      cursor_q      <= '0;
      head_q        <= '0;
      overflow_q    <= 1'b0;
      done_q        <= 1'b0;
      save_drop_q   <= 1'b0;
      can_undo_q    <= 1'b0;
      can_redo_q    <= 1'b0;
      busy_q        <= 1'b0;
      out_valid_q   <= 1'b0;
      out_is_redo_q <= 1'b0;
      x_out_q       <= '0;
      y_out_q       <= '0;
      col_out_q     <= '0;
    end else begin
      state_q       <= state_d;
      tail_q        <= tail_d;
      cursor_q      <= cursor_d;
      head_q        <= head_d;
      overflow_q    <= overflow_d;
      done_q        <= done_d;
      save_drop_q   <= save_drop_d;
      can_undo_q    <= can_undo_d;
      can_redo_q    <= can_redo_d;
      busy_q        <= busy_d;
      out_valid_q   <= out_valid_d;
      out_is_redo_q <= out_is_redo_d;
      x_out_q       <= x_out_d;
      y_out_q       <= y_out_d;
      col_out_q     <= col_out_d;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_is_redo = out_is_redo_q;
  assign bus.x_out       = x_out_q;
  assign bus.y_out       = y_out_q;
  assign bus.col_out     = col_out_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.can_undo    = can_undo_q;
  assign bus.can_redo    = can_redo_q;
  assign bus.overflow    = overflow_q;
  assign bus.save_drop   = save_drop_q;

endmodule
